// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds arbitration state encoding, DMA request bundle and word func3.
package dmem_arbiter_pkg;

    typedef enum logic {
        CPU_PRI = 1'b0,
        DMA_PRI = 1'b1
    } arb_state_t;

    localparam logic [2:0] FUNC3_WORD = 3'b010;

    localparam int DMEM_AW = 9;
    localparam int DMEM_DW = 32;

    typedef struct packed {
        logic               we;
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] wdata;
    } dma_req_t;

    // Count value at which the DMA port has waited long enough.
    function automatic logic [3:0] starve_limit(input int starve_max);
        return 4'(starve_max - 1);
    endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating 4-bit starvation counter for the DMA requester.
// hit flags that the next denial reaches the starvation bound.
module dmem_starve_ctr
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic hit
);

    logic [3:0] cnt;

    // Clear wins over increment; saturate rather than wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (clear) begin
            cnt <= 4'd0;
        end else if (inc && cnt != 4'hF) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign hit = (cnt == starve_limit(STARVE_MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: MEM stage (priority) vs DMA/debug port.
// Define DMEM_ARB_PERF_EN to add stall/DMA performance counters.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [DM_ADDRESS-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [2:0]            cpu_func3,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dma_valid,
    output logic                  dma_ready,
    input  logic                  dma_we,
    input  logic [DM_ADDRESS-1:0] dma_addr,
    input  logic [DATA_W-1:0]     dma_wdata,
    output logic                  dma_rvalid,
    output logic [DATA_W-1:0]     dma_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_dma_cnt
`endif
);

    arb_state_t state;
    arb_state_t state_nxt;
    dma_req_t   dma_req;
    logic       cpu_req;
    logic       cpu_gnt;
    logic       dma_gnt;
    logic       hs;
    logic       starve_hit;
    logic       starve_clr;
    logic       starve_inc;

    assign cpu_req = cpu_rd | cpu_wr;
    assign dma_req = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};

    // Arbitration state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CPU_PRI;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant decision and next state; reset masks every grant.
    always_comb begin
        cpu_gnt   = 1'b0;
        dma_gnt   = 1'b0;
        state_nxt = state;
        unique case (state)
            CPU_PRI: begin
                if (cpu_req) begin
                    cpu_gnt = 1'b1;
                end else if (dma_valid) begin
                    dma_gnt = 1'b1;
                end
                if (dma_valid && !dma_gnt && starve_hit) begin
                    state_nxt = DMA_PRI;
                end
            end
            DMA_PRI: begin
                if (dma_valid) begin
                    dma_gnt = 1'b1;
                end else if (cpu_req) begin
                    cpu_gnt = 1'b1;
                end
                if (dma_gnt || !dma_valid) begin
                    state_nxt = CPU_PRI;
                end
            end
            default: state_nxt = CPU_PRI;
        endcase
        if (reset) begin
            cpu_gnt = 1'b0;
            dma_gnt = 1'b0;
        end
    end

    assign hs        = dma_valid & dma_gnt;
    assign dma_ready = dma_gnt;
    assign cpu_stall = cpu_req & dma_gnt;
    assign cpu_rdata = mem_rdata;

    assign starve_inc = dma_valid & ~dma_gnt;
    assign starve_clr = hs | ~dma_valid
                      | (state == CPU_PRI && state_nxt == DMA_PRI);

    dmem_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .clear (starve_clr),
        .inc   (starve_inc),
        .hit   (starve_hit)
    );

    // Memory-side mux; idle port drives all zeros.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_func3 = 3'b000;
        if (dma_gnt) begin
            mem_rd    = ~dma_req.we;
            mem_wr    = dma_req.we;
            mem_addr  = dma_req.addr;
            mem_wdata = dma_req.wdata;
            mem_func3 = FUNC3_WORD;
        end else if (cpu_gnt) begin
            mem_rd    = cpu_rd & ~cpu_wr;
            mem_wr    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_func3 = cpu_func3;
        end
    end

    // Registered DMA read response, one cycle after the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= hs & ~dma_req.we;
            if (hs && !dma_req.we) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    // Event counters for stalled cycles and DMA handshakes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= 32'd0;
            perf_dma_cnt   <= 32'd0;
        end else begin
            if (cpu_stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (hs) begin
                perf_dma_cnt <= perf_dma_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with directed vectors.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_func3;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_valid, dma_ready, dma_we;
    logic [8:0]  dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_rd, mem_wr;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_func3;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall_cnt, perf_dma_cnt;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DM_ADDRESS (9),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_func3  (cpu_func3),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_valid  (dma_valid),
        .dma_ready  (dma_ready),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_func3  (mem_func3),
        .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_dma_cnt   (perf_dma_cnt)
`endif
    );

    // Simple word memory, combinational read.
    logic [31:0] mem [512];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    typedef struct {
        logic        rst, crd, cwr;
        logic [8:0]  caddr;
        logic [31:0] cwd;
        logic [2:0]  cf3;
        logic        dv, dwe;
        logic [8:0]  da;
        logic [31:0] dwd;
        logic        rdy, stall, mrd, mwr;
        logic [8:0]  maddr;
        logic [2:0]  mf3;
        logic [31:0] mwd;
        logic        chk;
        logic [31:0] crdx;
        logic        rsp;
        logic [31:0] rspd;
    } vec_t;

    vec_t        cyc_q[$];
    logic [31:0] rsp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        prev_rsp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h @%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic rst, crd, cwr, input logic [8:0] caddr,
        input logic [31:0] cwd, input logic [2:0] cf3,
        input logic dv, dwe, input logic [8:0] da, input logic [31:0] dwd,
        input logic rdy, stall, mrd, mwr, input logic [8:0] maddr,
        input logic [2:0] mf3, input logic [31:0] mwd,
        input logic chk_c, input logic [31:0] crdx,
        input logic rsp, input logic [31:0] rspd);
        vec_t v;
        v.rst = rst; v.crd = crd; v.cwr = cwr; v.caddr = caddr;
        v.cwd = cwd; v.cf3 = cf3; v.dv = dv; v.dwe = dwe;
        v.da = da; v.dwd = dwd; v.rdy = rdy; v.stall = stall;
        v.mrd = mrd; v.mwr = mwr; v.maddr = maddr; v.mf3 = mf3;
        v.mwd = mwd; v.chk = chk_c; v.crdx = crdx;
        v.rsp = rsp; v.rspd = rspd;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int n);
        for (int i = 0; i < n; i++) begin
            reset     = v.rst;
            cpu_rd    = v.crd;
            cpu_wr    = v.cwr;
            cpu_addr  = v.caddr;
            cpu_wdata = v.cwd;
            cpu_func3 = v.cf3;
            dma_valid = v.dv;
            dma_we    = v.dwe;
            dma_addr  = v.da;
            dma_wdata = v.dwd;
            cyc_q.push_back(v);
            if (v.rsp) rsp_q.push_back(v.rspd);
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: per-cycle expectations and DMA response pulses.
    always @(negedge clk) begin
        vec_t e;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("dma_ready", 32'(dma_ready), 32'(e.rdy));
            chk("cpu_stall", 32'(cpu_stall), 32'(e.stall));
            chk("mem_rd", 32'(mem_rd), 32'(e.mrd));
            chk("mem_wr", 32'(mem_wr), 32'(e.mwr));
            chk("mem_addr", 32'(mem_addr), 32'(e.maddr));
            chk("mem_func3", 32'(mem_func3), 32'(e.mf3));
            chk("mem_wdata", mem_wdata, e.mwd);
            chk("dma_rvalid", 32'(dma_rvalid), 32'(prev_rsp));
            if (e.chk) chk("cpu_rdata", cpu_rdata, e.crdx);
            if (e.rst) chk("dma_rdata_rst", dma_rdata, 32'd0);
            prev_rsp = e.rsp;
        end
        if (dma_rvalid) begin
            if (rsp_q.size() == 0) begin
                chk("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                chk("dma_rdata", dma_rdata, rsp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t con, drop, dmaonly, rstc;
        reset = 1'b1;
        cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        cpu_func3 = 0; dma_valid = 0; dma_we = 0; dma_addr = 0;
        dma_wdata = 0;
        @(posedge clk);
        #1;
        // Reset: everything low.
        apply(mk(1,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0, 0,0, 0,0), 1);
        // CPU only: store then load.
        apply(mk(0,0,1,9'h10,32'hDEADBEEF,3'd2, 0,0,0,0,
                 0,0,0,1,9'h10,3'd2,32'hDEADBEEF, 0,0, 0,0), 1);
        apply(mk(0,1,0,9'h10,0,3'd2, 0,0,0,0,
                 0,0,1,0,9'h10,3'd2,0, 1,32'hDEADBEEF, 0,0), 1);
        // DMA only: write then read.
        apply(mk(0,0,0,0,0,0, 1,1,9'h20,32'h1234,
                 1,0,0,1,9'h20,3'd2,32'h1234, 0,0, 0,0), 1);
        apply(mk(0,0,0,0,0,0, 1,0,9'h20,0,
                 1,0,1,0,9'h20,3'd2,0, 0,0, 1,32'h1234), 1);
        apply(mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0, 0,0, 0,0), 1);
        // Back-to-back DMA reads.
        apply(mk(0,0,0,0,0,0, 1,0,9'h10,0,
                 1,0,1,0,9'h10,3'd2,0, 0,0, 1,32'hDEADBEEF), 1);
        apply(mk(0,0,0,0,0,0, 1,0,9'h20,0,
                 1,0,1,0,9'h20,3'd2,0, 0,0, 1,32'h1234), 1);
        // Contention: 4 denied cycles, then forced DMA grant.
        con = mk(0,1,0,9'h10,0,3'd4, 1,0,9'h20,0,
                 0,0,1,0,9'h10,3'd4,0, 1,32'hDEADBEEF, 0,0);
        apply(con, 4);
        apply(mk(0,1,0,9'h10,0,3'd4, 1,0,9'h20,0,
                 1,1,1,0,9'h20,3'd2,0, 0,0, 1,32'h1234), 1);
        apply(mk(0,1,0,9'h10,0,3'd4, 0,0,0,0,
                 0,0,1,0,9'h10,3'd4,0, 1,32'hDEADBEEF, 0,0), 1);
        // dma_valid dropped mid-starvation restarts the wait.
        drop = mk(0,1,0,9'h10,0,3'd2, 1,1,9'h30,32'h55,
                  0,0,1,0,9'h10,3'd2,0, 1,32'hDEADBEEF, 0,0);
        apply(drop, 2);
        apply(mk(0,1,0,9'h10,0,3'd2, 0,0,0,0,
                 0,0,1,0,9'h10,3'd2,0, 1,32'hDEADBEEF, 0,0), 1);
        apply(drop, 4);
        apply(mk(0,1,0,9'h10,0,3'd2, 1,1,9'h30,32'h55,
                 1,1,0,1,9'h30,3'd2,32'h55, 0,0, 0,0), 1);
        apply(mk(0,1,0,9'h30,0,3'd2, 0,0,0,0,
                 0,0,1,0,9'h30,3'd2,0, 1,32'h55, 0,0), 1);
        // DMA read handshake, then reset kills the response.
        apply(mk(0,0,0,0,0,0, 1,0,9'h30,0,
                 1,0,1,0,9'h30,3'd2,0, 0,0, 0,0), 1);
        rstc = mk(1,1,0,9'h10,0,3'd2, 1,0,9'h30,0,
                  0,0,0,0,0,0,0, 0,0, 0,0);
        apply(rstc, 1);
        // After reset: CPU_PRI with fresh counter, 10 cycles contention.
        con = mk(0,1,0,9'h10,0,3'd2, 1,0,9'h30,0,
                 0,0,1,0,9'h10,3'd2,0, 1,32'hDEADBEEF, 0,0);
        dmaonly = mk(0,1,0,9'h10,0,3'd2, 1,0,9'h30,0,
                     1,1,1,0,9'h30,3'd2,0, 0,0, 1,32'h55);
        apply(con, 4);
        apply(dmaonly, 1);
        apply(con, 4);
        apply(dmaonly, 1);
        apply(mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0, 0,0, 0,0), 2);
        @(negedge clk);
        chk("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
`ifdef DMEM_ARB_PERF_EN
        chk("perf_stall_cnt", perf_stall_cnt, 32'd2);
        chk("perf_dma_cnt", perf_dma_cnt, 32'd2);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single data memory between the pipeline MEM stage (EX/MEM register outputs) and a secondary DMA/debug requester (program loader, testbench backdoor). The CPU port has priority. A starvation counter forces a DMA grant after a bounded wait, stalling the pipeline for that cycle. DMA read data is returned through a registered response pulse.

## Interface
Parameters:
- DM_ADDRESS, 9, data memory address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive denied DMA cycles before a forced grant (legal range 1..15)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cpu_rd  in  1  MEM-stage read enable (C.MemRead)
- cpu_wr  in  1  MEM-stage write enable (C.MemWrite)
- cpu_addr  in  DM_ADDRESS  MEM-stage address
- cpu_wdata  in  DATA_W  MEM-stage store data
- cpu_func3  in  3  MEM-stage access size/sign
- cpu_rdata  out  DATA_W  read data to MEM/WB
- cpu_stall  out  1  pipeline hold request; CPU access not performed this cycle
- dma_valid  in  1  DMA request valid
- dma_ready  out  1  DMA request accepted this cycle
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  DM_ADDRESS  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_rvalid  out  1  one-cycle pulse: dma_rdata valid
- dma_rdata  out  DATA_W  registered DMA read data
- mem_rd, mem_wr  out  1 each  to data memory
- mem_addr  out  DM_ADDRESS  to data memory
- mem_wdata  out  DATA_W  to data memory
- mem_func3  out  3  to data memory
- mem_rdata  in  DATA_W  from data memory (combinational read, same cycle)

## Operation
- cpu_req = cpu_rd | cpu_wr. cpu_rd and cpu_wr both high: treated as write.
- FSM, 2 states. CPU_PRI: grant CPU if cpu_req, else DMA if dma_valid. DMA_PRI: grant DMA if dma_valid, else CPU.
- Transitions: CPU_PRI -> DMA_PRI when dma_valid, DMA denied, and starve_cnt == STARVE_MAX-1. DMA_PRI -> CPU_PRI on DMA handshake or when dma_valid is low.
- starve_cnt (4 bits): +1 each cycle dma_valid & !dma_ready; cleared on handshake, when dma_valid is low, and on entry to DMA_PRI.
- Grant and mux are combinational from current state and requests. dma_ready = DMA granted. cpu_stall = cpu_req & DMA granted.
- DMA accesses are always word: mem_func3 = 3'b010. Neither port granted: mem_rd = mem_wr = 0, addr/wdata/func3 = 0.
- cpu_rdata = mem_rdata unconditionally. The pipeline ignores it while cpu_stall is high.
- DMA read handshake: next cycle dma_rvalid = 1 and dma_rdata = mem_rdata sampled at the handshake edge. dma_rdata holds until the next read. DMA write: no response.
- DMA protocol: dma_valid, dma_addr, dma_we and dma_wdata must be held stable until dma_ready.
- Integration: the datapath freezes the EX/MEM register and the upstream stages while cpu_stall is high, and re-presents the same access next cycle.

## Timing
- Reset (asynchronous): state = CPU_PRI, starve_cnt = 0, dma_rvalid = 0, dma_rdata = 0. While reset is high, all combinational outputs are forced low: dma_ready, cpu_stall, and mem_*.
- Grant latency: 0 cycles, same cycle as the request. DMA read response latency: 1 cycle.
- Continuous CPU traffic with dma_valid held: DMA denied for STARVE_MAX cycles and granted on cycle STARVE_MAX+1. cpu_stall is high for that one cycle.
- STARVE_MAX = 1: every other cycle goes to DMA under contention.
- Back-to-back DMA reads with the CPU idle: one accepted per cycle, and dma_rvalid is high every cycle.
- Reset asserted mid-operation: a pending dma_rvalid is dropped (0 after reset), and the in-flight request must be re-issued.

## Configuration
- DMEM_ARB_PERF_EN defined: adds outputs perf_stall_cnt [31:0] (cycles with cpu_stall high) and perf_dma_cnt [31:0] (DMA handshakes). Both counters are reset to 0, wrap at 2^32, and are incremented by the same clock edge as the event.
- DMEM_ARB_PERF_EN undefined: the ports and counters do not exist. Arbitration behaviour is identical in both builds.

## Structure
- In Pipe_Buf_Reg_PKG (or a sibling arb package):
  - typedef enum arb_state_t {CPU_PRI, DMA_PRI}
  - localparam FUNC3_WORD = 3'b010
  - struct dma_req_t {we, addr, wdata}
- Sub-module dmem_starve_ctr: saturating counter with clear, inc and a hit output. The FSM and mux stay in dmem_arbiter.

## Test plan
- CPU only: cpu_wr, addr 0x10, data 0xDEADBEEF, then cpu_rd at 0x10 -> mem_wr/mem_rd pass through, cpu_rdata = 0xDEADBEEF, cpu_stall = 0 throughout.
- DMA only: write 0x1234 to 0x20, then read 0x20 -> dma_ready same cycle, dma_rvalid one cycle after the read with dma_rdata = 0x1234, mem_func3 = 3'b010.
- Contention with STARVE_MAX = 4: cpu_rd every cycle, dma_valid from cycle 0 -> dma_ready low cycles 0-3, high cycle 4 with cpu_stall = 1, CPU regains the memory at cycle 5.
- dma_valid dropped at cycle 2 of starvation and re-raised -> starve_cnt cleared, full 4-cycle wait again.
- Reset pulse the cycle after a DMA read handshake -> dma_rvalid stays 0, all outputs low during reset, state = CPU_PRI afterwards.
- With DMEM_ARB_PERF_EN: contention scenario for 10 cycles -> perf_stall_cnt = 2, perf_dma_cnt = 2.
